// File: rtl/gpu_mem_pkg.sv
// Shared memory-path types: arbiter FSM states, latched request payload and
// the default bus widths used by memory_controller and cache_hierarchy.
package gpu_mem_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and controller-side signals of mem_port_arbiter.
// The arbiter takes the slave modport; the environment takes master.
interface mem_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = gpu_mem_pkg::MEM_ADDR_W,
  parameter int unsigned DATA_W  = gpu_mem_pkg::MEM_DATA_W
);

  logic [NUM_REQ-1:0]        req_en;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_rdata;
  logic                      resp_err;
  logic [ADDR_W-1:0]         int_addr;
  logic                      int_read;
  logic                      int_write;
  logic [DATA_W-1:0]         int_wdata;
  logic [DATA_W-1:0]         int_rdata;
  logic                      int_ready;
  logic                      busy;
  logic                      timeout_sticky;

  modport slave (
    input  req_en, req_valid, req_we, req_addr, req_wdata, int_rdata, int_ready,
    output req_ready, resp_valid, resp_rdata, resp_err,
           int_addr, int_read, int_write, int_wdata, busy, timeout_sticky
  );

  modport master (
    output req_en, req_valid, req_we, req_addr, req_wdata, int_rdata, int_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           int_addr, int_read, int_write, int_wdata, busy, timeout_sticky
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of req_i at or above
// start_i, wrapping to the lowest set bit; one-hot result plus found flag.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] start_i,
  output logic [N-1:0]     gnt_o,
  output logic             found_o
);

  logic [N-1:0] upper_c;
  logic [N-1:0] pool_c;

  always_comb begin
    upper_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      upper_c[i] = req_i[i] && (i >= int'(start_i));
    end
    pool_c = (|upper_c) ? upper_c : req_i;
    gnt_o  = '0;
    // Descending scan so the lowest set bit of the pool wins.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (pool_c[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
      end
    end
  end

  assign found_o = |req_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates NUM_REQ requesters onto the single memory_controller port:
// priority requester 0 with a starvation guard, round-robin for the rest.
module mem_port_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = MEM_ADDR_W,
  parameter int unsigned DATA_W  = MEM_DATA_W,
  parameter int unsigned HP_MAX  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_2GHz,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned HP_W  = $clog2(HP_MAX + 1);
  localparam int unsigned WD_W  = 16;

  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [HP_W-1:0]  HP_SAT   = HP_W'(HP_MAX);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(1);
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_e        state_q, state_d;
  mem_req_t          req_q, req_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [HP_W-1:0]   hp_streak_q, hp_streak_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              sticky_q, sticky_d;

  logic [NUM_REQ-1:0] elig_c, rr_req_c, rr_gnt_c, gnt_c, resp_valid_c;
  logic               rr_found_c, take_hp_c;
  logic [IDX_W-1:0]   rr_idx_c;

  assign elig_c    = bus.req_valid & bus.req_en;
  assign rr_req_c  = {elig_c[NUM_REQ-1:1], 1'b0};
  assign take_hp_c = elig_c[0] && !((hp_streak_q == HP_SAT) && (|rr_req_c));

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (IDX_W)
  ) u_rr_pick (
    .req_i   (rr_req_c),
    .start_i (rr_ptr_q),
    .gnt_o   (rr_gnt_c),
    .found_o (rr_found_c)
  );

  // One-hot round-robin grant to index.
  always_comb begin
    rr_idx_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (rr_gnt_c[i]) rr_idx_c = IDX_W'(i);
    end
  end

  always_ff @(posedge clk_2GHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      win_q       <= '0;
      rr_ptr_q    <= PTR_RST;
      hp_streak_q <= '0;
      wd_cnt_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      win_q       <= win_d;
      rr_ptr_q    <= rr_ptr_d;
      hp_streak_q <= hp_streak_d;
      wd_cnt_q    <= wd_cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    win_d       = win_q;
    rr_ptr_d    = rr_ptr_q;
    hp_streak_d = hp_streak_q;
    wd_cnt_d    = wd_cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    sticky_d    = sticky_q;
    gnt_c       = '0;
    unique case (state_q)
      IDLE: begin
        // Acceptance is combinational; rst_n keeps req_ready low during reset.
        if (rst_n && (take_hp_c || rr_found_c)) begin
          if (take_hp_c) begin
            gnt_c = NUM_REQ'(1);
            win_d = '0;
            if (hp_streak_q != HP_SAT) hp_streak_d = hp_streak_q + HP_W'(1);
          end else begin
            gnt_c       = rr_gnt_c;
            win_d       = rr_idx_c;
            hp_streak_d = '0;
            rr_ptr_d    = (rr_idx_c == PTR_LAST) ? PTR_RST : rr_idx_c + IDX_W'(1);
          end
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_c[i]) begin
              req_d.we    = bus.req_we[i];
              req_d.addr  = MEM_ADDR_W'(bus.req_addr[i*ADDR_W +: ADDR_W]);
              req_d.wdata = MEM_DATA_W'(bus.req_wdata[i*DATA_W +: DATA_W]);
            end
          end
          wd_cnt_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (bus.int_ready) begin
          rdata_d = bus.int_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_cnt_q == WD_LAST) begin
          rdata_d  = '0;
          err_d    = 1'b1;
          sticky_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp_valid_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      resp_valid_c[i] = (state_q == RESP) && (win_q == IDX_W'(i));
    end
  end

  assign bus.req_ready      = gnt_c;
  assign bus.resp_valid     = resp_valid_c;
  assign bus.resp_rdata     = rdata_q;
  assign bus.resp_err       = (state_q == RESP) && err_q;
  assign bus.int_addr       = ADDR_W'(req_q.addr);
  assign bus.int_wdata      = DATA_W'(req_q.wdata);
  assign bus.int_read       = (state_q == ISSUE) && !req_q.we;
  assign bus.int_write      = (state_q == ISSUE) && req_q.we;
  assign bus.busy           = (state_q != IDLE);
  assign bus.timeout_sticky = sticky_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction table with a response scoreboard,
// plus hand sequences for exact single-read timing and mid-issue reset.
module tb_mem_port_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 256;
  localparam int unsigned HP_MAX  = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int          NV      = 23;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] en;
    logic [3:0] en_after;
    logic [3:0] we;
    int         lat;
    bit         hang;
    int         exp_win;
  } vec_t;

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] data;
    bit                err;
    bit                chk_data;
  } sb_t;

  logic clk_2GHz = 1'b0;
  logic rst_n    = 1'b0;
  int   total    = 0;
  int   bad      = 0;
  int   mem_lat  = 0;
  bit   mem_hang = 1'b0;
  int   iss_cnt;
  sb_t  sb[$];
  sb_t  mon_e;
  logic [3:0] mon_v;
  vec_t tbl[NV];

  mem_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .HP_MAX  (HP_MAX),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_2GHz (clk_2GHz),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk_2GHz = ~clk_2GHz;

  function automatic logic [ADDR_W-1:0] addr_of(input int i, input int r);
    return 32'h2000 + 32'(r) * 32'h40 + 32'(i) * 32'h4;
  endfunction

  function automatic logic [DATA_W-1:0] wdata_of(input logic [ADDR_W-1:0] a);
    return {8{~a}};
  endfunction

  function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
    return {8{32'hABAB_ABAB ^ (a - 32'h1000)}};
  endfunction

  // Downstream memory: completes after mem_lat extra ISSUE cycles unless hung.
  always @(posedge clk_2GHz or negedge rst_n) begin
    if (!rst_n) iss_cnt <= 0;
    else if (bus.int_read || bus.int_write) iss_cnt <= iss_cnt + 1;
    else iss_cnt <= 0;
  end
  assign bus.int_ready = (bus.int_read || bus.int_write) && !mem_hang && (iss_cnt == mem_lat);
  assign bus.int_rdata = mem_data(bus.int_addr);

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] en, input logic [3:0] we, input int r);
    bus.req_valid = v;
    bus.req_en    = en;
    bus.req_we    = we;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      bus.req_addr[i*ADDR_W +: ADDR_W]  = addr_of(i, r);
      bus.req_wdata[i*DATA_W +: DATA_W] = wdata_of(addr_of(i, r));
    end
  endtask

  // Response scoreboard.
  always @(negedge clk_2GHz) begin
    if (rst_n && bus.resp_valid != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", bus.resp_valid, '0);
      end else begin
        mon_e = sb.pop_front();
        mon_v = '0;
        mon_v[mon_e.idx] = 1'b1;
        chk("resp_valid", bus.resp_valid, mon_v);
        chk("resp_err", bus.resp_err, mon_e.err);
        if (mon_e.chk_data) chk("resp_rdata", bus.resp_rdata, mon_e.data);
      end
    end
  end

  // Caller enters at posedge+1 with the DUT in IDLE; returns at the RESP negedge.
  task automatic run_txn(input vec_t v, input int r);
    logic [3:0]        exp_gnt;
    logic [ADDR_W-1:0] ea;
    sb_t               e;
    int                w_cnt;
    bit                done;
    bit                we;
    mem_lat  = v.lat;
    mem_hang = v.hang;
    drive(v.valid, v.en, v.we, r);
    exp_gnt = '0;
    exp_gnt[v.exp_win] = 1'b1;
    @(negedge clk_2GHz);
    chk($sformatf("grant_row%0d", r), bus.req_ready, exp_gnt);
    ea         = addr_of(v.exp_win, r);
    we         = v.we[v.exp_win];
    e.idx      = v.exp_win;
    e.err      = v.hang;
    e.data     = v.hang ? '0 : mem_data(ea);
    e.chk_data = v.hang || !we;
    sb.push_back(e);
    @(posedge clk_2GHz); #1;
    bus.req_en = v.en_after;
    w_cnt = 0;
    done  = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk_2GHz);
      if (bus.resp_valid != '0) begin
        done = 1'b1;
      end else begin
        w_cnt++;
        chk("int_addr", bus.int_addr, ea);
        chk("int_read", bus.int_read, !we);
        chk("int_write", bus.int_write, we);
        chk("busy", bus.busy, 1'b1);
        if (we) chk("int_wdata", bus.int_wdata, wdata_of(ea));
        @(posedge clk_2GHz); #1;
      end
    end
    if (!done) chk("resp_wait_expired", 1'b0, 1'b1);
    chk($sformatf("issue_cycles_row%0d", r), w_cnt, v.hang ? TIMEOUT : v.lat + 1);
  endtask

  initial begin
    vec_t rv;
    sb_t  e;
    // Starvation guard: 0 and 1 always valid.
    for (int i = 0; i < 10; i++)
      tbl[i] = '{4'b0011, 4'b1111, 4'b1111, 4'b0010, 0, 1'b0, (i == 4 || i == 9) ? 1 : 0};
    tbl[10] = '{4'b1000, 4'b1111, 4'b1111, 4'b1000, 2, 1'b0, 3};
    tbl[11] = '{4'b1110, 4'b1111, 4'b1111, 4'b0100, 1, 1'b0, 1};
    tbl[12] = '{4'b1110, 4'b1111, 4'b1111, 4'b0100, 1, 1'b0, 2};
    tbl[13] = '{4'b1110, 4'b1111, 4'b1111, 4'b0100, 1, 1'b0, 3};
    tbl[14] = '{4'b1110, 4'b1111, 4'b1111, 4'b0100, 1, 1'b0, 1};
    tbl[15] = '{4'b1110, 4'b1111, 4'b1011, 4'b0000, 3, 1'b0, 2};
    tbl[16] = '{4'b1110, 4'b1011, 4'b1011, 4'b0000, 0, 1'b0, 3};
    tbl[17] = '{4'b1110, 4'b1011, 4'b1011, 4'b0000, 0, 1'b0, 1};
    tbl[18] = '{4'b1110, 4'b1011, 4'b1011, 4'b0000, 0, 1'b0, 3};
    tbl[19] = '{4'b1111, 4'b1110, 4'b1110, 4'b0000, 0, 1'b0, 1};
    tbl[20] = '{4'b0001, 4'b1111, 4'b1111, 4'b0000, 7, 1'b0, 0};
    tbl[21] = '{4'b0001, 4'b1111, 4'b1111, 4'b0000, 0, 1'b1, 0};
    tbl[22] = '{4'b1000, 4'b1111, 4'b1111, 4'b1000, 0, 1'b1, 3};

    drive(4'b0000, 4'b1111, 4'b0000, 0);
    #12;
    chk("rst_req_ready", bus.req_ready, '0);
    chk("rst_resp_valid", bus.resp_valid, '0);
    chk("rst_int_read", bus.int_read, 1'b0);
    chk("rst_int_write", bus.int_write, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_sticky", bus.timeout_sticky, 1'b0);
    chk("rst_int_addr", bus.int_addr, '0);
    chk("rst_resp_rdata", bus.resp_rdata, '0);
    #1 rst_n = 1'b1;

    // Single read from requester 2, completion one cycle after ISSUE entry.
    @(posedge clk_2GHz); #1;
    mem_lat  = 1;
    mem_hang = 1'b0;
    drive(4'b0100, 4'b1111, 4'b0000, 0);
    bus.req_addr[2*ADDR_W +: ADDR_W] = 32'h1000;
    @(negedge clk_2GHz);
    chk("sr_req_ready_T", bus.req_ready, 4'b0100);
    e = '{2, mem_data(32'h1000), 1'b0, 1'b1};
    sb.push_back(e);
    @(posedge clk_2GHz); #1;
    bus.req_valid = '0;
    @(negedge clk_2GHz);
    chk("sr_int_read_T1", bus.int_read, 1'b1);
    chk("sr_int_addr_T1", bus.int_addr, 32'h1000);
    chk("sr_resp_T1", bus.resp_valid, '0);
    @(posedge clk_2GHz); #1;
    @(negedge clk_2GHz);
    chk("sr_int_read_T2", bus.int_read, 1'b1);
    chk("sr_resp_T2", bus.resp_valid, '0);
    @(posedge clk_2GHz); #1;
    @(negedge clk_2GHz);
    chk("sr_resp_valid_T3", bus.resp_valid, 4'b0100);
    chk("sr_resp_rdata_T3", bus.resp_rdata, {8{32'hABAB_ABAB}});
    chk("sr_resp_err_T3", bus.resp_err, 1'b0);
    chk("sr_int_read_T3", bus.int_read, 1'b0);
    @(posedge clk_2GHz); #1;
    @(negedge clk_2GHz);
    chk("sr_busy_T4", bus.busy, 1'b0);

    for (int r = 0; r < NV; r++) begin
      @(posedge clk_2GHz); #1;
      if (r == 21) chk("sticky_after_ready_on_last_cycle", bus.timeout_sticky, 1'b0);
      run_txn(tbl[r], r + 1);
    end
    @(posedge clk_2GHz); #1;
    chk("sticky_after_timeout", bus.timeout_sticky, 1'b1);

    // Reset while a write is stuck in ISSUE.
    mem_hang = 1'b1;
    drive(4'b0010, 4'b1111, 4'b0010, 40);
    @(negedge clk_2GHz);
    chk("prerst_grant", bus.req_ready, 4'b0010);
    @(posedge clk_2GHz); #1;
    @(negedge clk_2GHz);
    chk("prerst_int_write", bus.int_write, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_int_write", bus.int_write, 1'b0);
    chk("arst_int_read", bus.int_read, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_req_ready", bus.req_ready, '0);
    chk("arst_resp_valid", bus.resp_valid, '0);
    chk("arst_int_addr", bus.int_addr, '0);
    chk("arst_int_wdata", bus.int_wdata, '0);
    chk("arst_resp_err", bus.resp_err, 1'b0);
    chk("arst_sticky", bus.timeout_sticky, 1'b0);
    @(posedge clk_2GHz); #3;
    rst_n         = 1'b1;
    mem_hang      = 1'b0;
    bus.req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_2GHz); #1;
      @(negedge clk_2GHz);
      chk("postrst_idle", bus.busy, 1'b0);
    end
    @(posedge clk_2GHz); #1;
    rv = '{4'b1110, 4'b1111, 4'b1111, 4'b0000, 0, 1'b0, 1};
    run_txn(rv, 41);

    @(posedge clk_2GHz); #1;
    @(negedge clk_2GHz);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired required finish");
    $fatal(1);
  end

endmodule
